// File: rtl/nv_ram_rwsthp_20x16_fifo_ctrl.sv
// nv_ram_rwsthp_20x16_fifo_ctrl
// Runs an external 20x16 registered-output two-port RAM as a valid/ready FIFO.
// Owns the write/read pointers, the occupancy count and the two-stage read
// pipeline: stage 1 is the RAM address register (re), stage 2 is the RAM
// output register (ore). A slot is only freed on pop, so a stalled stage
// keeps its address/data stable simply by holding re/ore low.
module nv_ram_rwsthp_20x16_fifo_ctrl (
    input  logic        clk,
    input  logic        rst,
    // producer side
    input  logic        wr_vld,
    output logic        wr_rdy,
    input  logic [15:0] wr_pd,
    // consumer side
    output logic        rd_vld,
    input  logic        rd_rdy,
    output logic [15:0] rd_pd,
    // status
    output logic [4:0]  fifo_cnt,
    // power bus pass-through
    input  logic [31:0] pwrbus_ram_pd,
    // RAM write port
    output logic [4:0]  ram_wa,
    output logic        ram_we,
    output logic [15:0] ram_di,
    // RAM read port
    output logic [4:0]  ram_ra,
    output logic        ram_re,
    output logic        ram_ore,
    // RAM bypass (unused)
    output logic        ram_byp_sel,
    output logic [15:0] ram_dbyp,
    // RAM data out and power bus
    input  logic [15:0] ram_dout,
    output logic [31:0] ram_pwrbus_ram_pd
);

    // Geometry is fixed by the RAM macro.
    localparam int DEPTH = 20;
    localparam int WIDTH = 16;
    localparam int AW    = 5;
    localparam int CW    = 5;

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // State
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] unread;
    logic          s1_vld;
    logic          s2_vld;

    // Per-cycle events
    logic push;
    logic pop;
    logic adv;
    logic issue;
    logic load;

    // Pointer increment with wrap at the last RAM entry.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    // Handshake and pipeline control; wr_rdy comes only from registers so
    // there is no combinational path from rd_rdy back to the producer.
    always_comb begin
        wr_rdy = (cnt != FULL_CNT);
        push   = wr_vld && wr_rdy;
        pop    = s2_vld && rd_rdy;
        adv    = !s2_vld || rd_rdy;
        issue  = (unread != '0) && (!s1_vld || adv);
        load   = s1_vld && adv;
    end

    // RAM port drives and status outputs.
    always_comb begin
        ram_we            = push;
        ram_wa            = wr_ptr;
        ram_di            = wr_pd;
        ram_re            = issue;
        ram_ra            = rd_ptr;
        ram_ore           = load;
        ram_byp_sel       = 1'b0;
        ram_dbyp          = '0;
        ram_pwrbus_ram_pd = pwrbus_ram_pd;
        rd_vld            = s2_vld;
        rd_pd             = ram_dout;
        fifo_cnt          = cnt;
    end

    // Write pointer advances on every accepted push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
        end
    end

    // Read pointer advances on every address issued to the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (issue) begin
            rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // Entries written but not yet issued; a push this cycle is only
    // issuable next cycle because unread is sampled before the increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            unread <= '0;
        end else begin
            case ({push, issue})
                2'b10:   unread <= unread + CW'(1);
                2'b01:   unread <= unread - CW'(1);
                default: unread <= unread;
            endcase
        end
    end

    // Occupancy: everything pushed and not yet popped, including entries
    // sitting in the address or output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Read pipeline valids: stage 1 tracks the RAM address register,
    // stage 2 tracks the RAM output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
        end else begin
            s1_vld <= issue || (s1_vld && !adv);
            s2_vld <= load  || (s2_vld && !rd_rdy);
        end
    end

    // WIDTH is carried for documentation of the fixed data path.
    logic unused_width;
    assign unused_width = (WIDTH == 16);

endmodule

// File: tb/tb_nv_ram_rwsthp_20x16_fifo_ctrl.sv
// Testbench for nv_ram_rwsthp_20x16_fifo_ctrl. Includes a behavioural model
// of the registered-output RAM and a queue-based reference FIFO.
module tb_nv_ram_rwsthp_20x16_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_vld = 1'b0;
    logic        wr_rdy;
    logic [15:0] wr_pd = '0;
    logic        rd_vld;
    logic        rd_rdy = 1'b0;
    logic [15:0] rd_pd;
    logic [4:0]  fifo_cnt;
    logic [31:0] pwrbus_ram_pd = 32'h1357_9bdf;
    logic [4:0]  ram_wa;
    logic        ram_we;
    logic [15:0] ram_di;
    logic [4:0]  ram_ra;
    logic        ram_re;
    logic        ram_ore;
    logic        ram_byp_sel;
    logic [15:0] ram_dbyp;
    logic [15:0] ram_dout;
    logic [31:0] ram_pwrbus_ram_pd;

    nv_ram_rwsthp_20x16_fifo_ctrl dut (
        .clk(clk), .rst(rst),
        .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_pd(wr_pd),
        .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_pd(rd_pd),
        .fifo_cnt(fifo_cnt), .pwrbus_ram_pd(pwrbus_ram_pd),
        .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore),
        .ram_byp_sel(ram_byp_sel), .ram_dbyp(ram_dbyp),
        .ram_dout(ram_dout), .ram_pwrbus_ram_pd(ram_pwrbus_ram_pd)
    );

    always #5 clk = ~clk;

    // RAM model: write at clock edge, re captures address, ore captures data.
    logic [15:0] mem [0:19];
    logic [4:0]  ra_d = '0;
    logic [15:0] dout_r = '0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_d <= ram_ra;
        if (ram_ore) dout_r <= mem[ra_d];
    end
    assign ram_dout = dout_r;

    // Reference FIFO and per-cycle snapshot
    logic [15:0] q[$];
    int          m_wr_idx;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          s_push, s_pop, s_exp_ok;
    logic [15:0] s_got, s_exp;
    int          s_cnt_exp;
    int          s_wa_exp;

    // Drive one cycle's inputs, then update the reference from the handshake.
    task automatic step(input bit wv, input logic [15:0] wd, input bit rr);
        @(negedge clk);
        wr_vld = wv; wr_pd = wd; rd_rdy = rr;
        #1;
        s_cnt_exp = q.size();
        s_wa_exp  = m_wr_idx % 20;
        s_push    = wr_vld && wr_rdy;
        s_pop     = rd_vld && rd_rdy;
        s_exp_ok  = 1'b0;
        s_got     = rd_pd;
        s_exp     = 16'hxxxx;
        if (s_pop && q.size() > 0) begin
            s_exp = q.pop_front();
            s_exp_ok = 1'b1;
        end
        if (s_push) begin
            q.push_back(wd);
            m_wr_idx++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; wr_vld = 1'b0; rd_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_wr_idx = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (wr_rdy !== 1'b1) $display("FAIL reset_wr_rdy got=%b want=1", wr_rdy); else n_pass++;
        n_chk++; if (rd_vld !== 1'b0) $display("FAIL reset_rd_vld got=%b want=0", rd_vld); else n_pass++;
        n_chk++; if (fifo_cnt !== 5'd0) $display("FAIL reset_cnt got=%0d want=0", fifo_cnt); else n_pass++;
        n_chk++; if ({ram_we, ram_re, ram_ore} !== 3'b000)
            $display("FAIL reset_enables got=%b want=000", {ram_we, ram_re, ram_ore}); else n_pass++;
        n_chk++; if ({ram_byp_sel, ram_dbyp} !== 17'd0)
            $display("FAIL bypass_tie got=%h want=0", {ram_byp_sel, ram_dbyp}); else n_pass++;
        n_chk++; if (ram_pwrbus_ram_pd !== pwrbus_ram_pd)
            $display("FAIL pwrbus got=%h want=%h", ram_pwrbus_ram_pd, pwrbus_ram_pd); else n_pass++;
    endtask

    // One word through an empty FIFO: re at 1, ore at 2, rd_vld at 3.
    task automatic test_single();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(k == 0, 16'hA5A5, 1'b1);
            n_chk++; if (rd_vld !== (k == 3)) $display("FAIL single_rd_vld cyc=%0d got=%b want=%b", k, rd_vld, k == 3); else n_pass++;
            n_chk++; if (ram_re !== (k == 1)) $display("FAIL single_re cyc=%0d got=%b want=%b", k, ram_re, k == 1); else n_pass++;
            n_chk++; if (ram_ore !== (k == 2)) $display("FAIL single_ore cyc=%0d got=%b want=%b", k, ram_ore, k == 2); else n_pass++;
            if (k == 3) begin
                n_chk++; if (rd_pd !== 16'hA5A5) $display("FAIL single_data got=%h want=a5a5", rd_pd); else n_pass++;
            end
            if (k == 4) begin
                n_chk++; if (fifo_cnt !== 5'd0) $display("FAIL single_cnt got=%0d want=0", fifo_cnt); else n_pass++;
            end
        end
    endtask

    // Fill to 20 with no consumer, then drain 20 in consecutive cycles.
    task automatic test_fill_drain();
        int pops;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'(i), 1'b0);
            n_chk++; if (wr_rdy !== 1'b1 || ram_wa !== 5'(s_wa_exp))
                $display("FAIL fill_push i=%0d rdy=%b wa=%0d want rdy=1 wa=%0d", i, wr_rdy, ram_wa, s_wa_exp); else n_pass++;
        end
        step(1'b1, 16'hDEAD, 1'b0);
        n_chk++; if (wr_rdy !== 1'b0 || fifo_cnt !== 5'd20 || ram_we !== 1'b0)
            $display("FAIL full_state rdy=%b cnt=%0d we=%b want 0/20/0", wr_rdy, fifo_cnt, ram_we); else n_pass++;
        pops = 0;
        for (int k = 0; k < 20; k++) begin
            step(k == 0, 16'hBEEF, 1'b1);
            if (k == 0) begin
                n_chk++; if (wr_rdy !== 1'b0) $display("FAIL full_push_pop_rdy got=%b want=0", wr_rdy); else n_pass++;
            end
            if (k == 1) begin
                n_chk++; if (wr_rdy !== 1'b1) $display("FAIL full_rdy_after_pop got=%b want=1", wr_rdy); else n_pass++;
            end
            if (s_pop) begin
                pops++;
                n_chk++; if (!s_exp_ok || s_got !== s_exp || s_got !== 16'(k))
                    $display("FAIL drain_data k=%0d got=%h want=%h", k, s_got, 16'(k)); else n_pass++;
            end
        end
        n_chk++; if (pops != 20) $display("FAIL drain_pops got=%0d want=20", pops); else n_pass++;
        step(1'b1, 16'h55AA, 1'b1);
        n_chk++; if (ram_we !== 1'b1 || ram_wa !== 5'd0)
            $display("FAIL wr_ptr_wrap we=%b wa=%0d want 1/0", ram_we, ram_wa); else n_pass++;
        for (int k = 0; k < 6; k++) step(1'b0, 16'h0, 1'b1);
        n_chk++; if (q.size() != 0 || fifo_cnt !== 5'd0)
            $display("FAIL wrap_drain left=%0d cnt=%0d want 0/0", q.size(), fifo_cnt); else n_pass++;
    endtask

    // Continuous stream with an always-ready consumer: no bubbles, cnt <= 3.
    task automatic test_back_to_back();
        int pops, first, last, max_cnt;
        do_reset();
        pops = 0; first = -1; last = -1; max_cnt = 0;
        for (int k = 0; k < 110; k++) begin
            step(k < 100, 16'(16'h1000 + k), 1'b1);
            if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
            if (s_pop) begin
                pops++;
                if (first < 0) first = k;
                last = k;
                n_chk++; if (!s_exp_ok || s_got !== s_exp)
                    $display("FAIL stream_data k=%0d got=%h want=%h", k, s_got, s_exp); else n_pass++;
            end
        end
        n_chk++; if (pops != 100 || first != 3 || last != 102)
            $display("FAIL stream_rate pops=%0d first=%0d last=%0d want 100/3/102", pops, first, last); else n_pass++;
        n_chk++; if (max_cnt > 3) $display("FAIL stream_max_cnt got=%0d want<=3", max_cnt); else n_pass++;
    endtask

    // Random push/pop against the reference queue, with output-stability check.
    task automatic test_random();
        bit          hold;
        logic [15:0] hold_pd;
        int          budget;
        do_reset();
        hold = 1'b0; hold_pd = '0;
        for (int k = 0; k < 2000; k++) begin
            step(1'($urandom_range(1)), 16'($urandom), 1'($urandom_range(1)));
            n_chk++; if (int'(fifo_cnt) != s_cnt_exp || wr_rdy !== (s_cnt_exp != 20))
                $display("FAIL rand_cnt k=%0d cnt=%0d rdy=%b want %0d", k, fifo_cnt, wr_rdy, s_cnt_exp); else n_pass++;
            if (s_push) begin
                n_chk++; if (ram_wa !== 5'(s_wa_exp) || ram_di !== wr_pd)
                    $display("FAIL rand_wr k=%0d wa=%0d want=%0d", k, ram_wa, s_wa_exp); else n_pass++;
            end
            if (hold) begin
                n_chk++; if (rd_vld !== 1'b1 || rd_pd !== hold_pd)
                    $display("FAIL rand_hold k=%0d vld=%b pd=%h want 1/%h", k, rd_vld, rd_pd, hold_pd); else n_pass++;
            end
            if (s_pop) begin
                n_chk++; if (!s_exp_ok || s_got !== s_exp)
                    $display("FAIL rand_data k=%0d got=%h want=%h", k, s_got, s_exp); else n_pass++;
            end
            hold = rd_vld && !rd_rdy;
            hold_pd = rd_pd;
        end
        budget = 0;
        while (q.size() > 0 && budget < 100) begin
            step(1'b0, 16'h0, 1'b1);
            if (s_pop) begin
                n_chk++; if (!s_exp_ok || s_got !== s_exp)
                    $display("FAIL rand_drain got=%h want=%h", s_got, s_exp); else n_pass++;
            end
            budget++;
        end
        n_chk++; if (q.size() != 0) $display("FAIL rand_drain_timeout left=%0d want=0", q.size()); else n_pass++;
    endtask

    // Reset with 7 entries and both read stages full, then a fresh word.
    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 16'(16'h0700 + i), 1'b0);
        step(1'b0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b0);
        n_chk++; if (fifo_cnt !== 5'd7 || rd_vld !== 1'b1)
            $display("FAIL pre_reset cnt=%0d vld=%b want 7/1", fifo_cnt, rd_vld); else n_pass++;
        do_reset();
        n_chk++; if (fifo_cnt !== 5'd0 || rd_vld !== 1'b0 || wr_rdy !== 1'b1 || ram_re !== 1'b0 || ram_ore !== 1'b0)
            $display("FAIL mid_reset cnt=%0d vld=%b rdy=%b re=%b ore=%b want 0/0/1/0/0",
                     fifo_cnt, rd_vld, wr_rdy, ram_re, ram_ore); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            step(k == 0, 16'h1234, 1'b1);
            n_chk++; if (rd_vld !== (k == 3)) $display("FAIL post_reset_vld cyc=%0d got=%b want=%b", k, rd_vld, k == 3); else n_pass++;
            if (s_pop) begin
                n_chk++; if (s_got !== 16'h1234) $display("FAIL post_reset_data got=%h want=1234", s_got); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nv_ram_rwsthp_20x16_fifo_ctrl.md
# nv_ram_rwsthp_20x16_fifo_ctrl

Sequencing controller that runs the 20-entry x 16-bit registered-output two-port RAM (`nv_ram_rwsthp_20x16`, instanced outside this block) as a fully pipelined valid/ready FIFO. It owns the write/read pointers, the occupancy count and the two-stage read pipeline (`re` address capture, then `ore` data capture). It sustains one push and one pop per cycle under arbitrary backpressure. It sits between a 16-bit producer and consumer inside a core datapath, and exports RAM port drives plus status.

## Interface
- DEPTH, 20, RAM entries; fixed to the RAM macro, not overridable.
- WIDTH, 16, data width; fixed.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- wr_vld  in  1  producer push request.
- wr_rdy  out  1  push accepted when `wr_vld && wr_rdy`.
- wr_pd  in  16  push data.
- rd_vld  out  1  consumer data valid.
- rd_rdy  in  1  consumer accept; a pop occurs when `rd_vld && rd_rdy`.
- rd_pd  out  16  pop data; driven directly from RAM `dout`.
- fifo_cnt  out  5  entries held, 0..20: pushed and not yet popped, including in-flight reads.
- pwrbus_ram_pd  in  32  passed unchanged to the RAM.
- ram_wa  out  5, ram_we  out  1, ram_di  out  16  RAM write port.
- ram_ra  out  5, ram_re  out  1, ram_ore  out  1  RAM read port.
- ram_byp_sel  out  1, ram_dbyp  out  16  tied to 0; bypass is unused.
- ram_dout  in  16  RAM registered output.
- ram_pwrbus_ram_pd  out  32  equals `pwrbus_ram_pd`.

## Operation
- State registers:
  - `wr_ptr`, `rd_ptr`: 5 bits, range 0..19; increment wraps 19 -> 0.
  - `fifo_cnt`: 0..20.
  - `unread`: 0..20; written entries not yet issued to the read port.
  - `s1_vld`: RAM `ra_d` holds a live address.
  - `s2_vld`: RAM `dout_r` holds live data.
- Push:
  - `push = wr_vld && wr_rdy`, where `wr_rdy = (fifo_cnt != 20)`.
  - `ram_we = push`, `ram_wa = wr_ptr`, `ram_di = wr_pd`.
  - On push, `wr_ptr` advances and `unread` increments.
- Pipeline advance: `adv = !s2_vld || rd_rdy`.
- Read issue:
  - `ram_re = (unread != 0) && (!s1_vld || adv)`, `ram_ra = rd_ptr`.
  - On issue, `rd_ptr` advances and `unread` decrements.
  - `s1_vld` next = `ram_re`, or `s1_vld && !adv`.
- Output load:
  - `ram_ore = s1_vld && adv`.
  - `s2_vld` next = `ram_ore`, or `s2_vld && !rd_rdy`.
- Output: `rd_vld = s2_vld`, `rd_pd = ram_dout`.
- Count: `fifo_cnt` +1 on push only, -1 on pop only, unchanged when both or neither occur.
- A stalled stage holds because `re`/`ore` are low. Slots are not freed until pop, so `ra_d` and `dout_r` stay stable.
- Simultaneous push and pop at `fifo_cnt == 20`: `wr_rdy` is 0, so no push happens; the next cycle `wr_rdy` = 1. No combinational ready path from `rd_rdy` to `wr_rdy`.
- Simultaneous push and issue with `unread == 0`: no issue this cycle; issue occurs the next cycle.
- Reset mid-operation discards all contents. RAM array contents are not cleared; they are don't-care.
- Reset values: `wr_ptr = rd_ptr = 0`, `fifo_cnt = unread = 0`, `s1_vld = s2_vld = 0`. Hence `rd_vld = 0`, `wr_rdy = 1`, `ram_we = ram_re = ram_ore = 0`.

## Timing
- Write: push in cycle N writes RAM at the end of N.
- Empty-to-output latency 3 cycles: push in N, `ram_re` in N+1, `ram_ore` in N+2, `rd_vld` = 1 in N+3.
- Steady state with `rd_rdy` = 1: one pop per cycle, no bubbles.
- `rd_rdy` low for K cycles: `ram_ore` low, and `ram_re` low once `s1_vld` = 1. Output resumes at full rate in the first cycle `rd_rdy` returns; no data lost or duplicated.
- `wr_rdy` and `fifo_cnt` depend only on registers. `ram_re`/`ram_ore` depend combinationally on `rd_rdy`.

## Test plan
- After reset: `wr_rdy` = 1, `rd_vld` = 0, `fifo_cnt` = 0, all RAM enables 0.
- Single push of 0xA5A5 in cycle 0 with `rd_rdy` = 1 -> `rd_vld` = 1 and `rd_pd` = 0xA5A5 in cycle 3 only; `fifo_cnt` back to 0 in cycle 4.
- 20 pushes (0x0000..0x0013) with `rd_rdy` = 0 -> `wr_rdy` = 0 and `fifo_cnt` = 20. Then `rd_rdy` = 1 -> pops 0x0000..0x0013 in order, 20 consecutive cycles; `wr_ptr` wraps to 0.
- Continuous push/pop of 100 incrementing words with `rd_rdy` = 1 -> full throughput, in order; `fifo_cnt` never exceeds 3; pointer wrap at 19 -> 0 is exercised five times.
- Random `wr_vld`/`rd_rdy` (50% each) over 2000 cycles vs. a scoreboard -> no loss, duplication or reorder. `rd_pd` stays stable while `rd_vld && !rd_rdy`.
- `rst` asserted with `fifo_cnt` = 7 and both pipeline stages full -> next cycle all counters and valids are 0. A push then pops correctly after 3 cycles.
